// File: rtl/fxp_q88_pkg.sv
// rtl/fxp_q88_pkg.sv - Q8.8 fixed-point constants, round/saturate helper and FSM encodings
package fxp_q88_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    // Wide working width for the rounding helper; any legal accumulator fits inside it.
    localparam int WIDE_WIDTH = 64;

    localparam logic signed [WIDE_WIDTH-1:0] SAT_MAX_W = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    localparam logic signed [WIDE_WIDTH-1:0] SAT_MIN_W = -(64'sd1 <<< (DATA_WIDTH - 1));
    localparam logic signed [WIDE_WIDTH-1:0] RND_HALF  = 64'sd1 <<< (FRAC_BITS - 1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(SAT_MAX_W);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(SAT_MIN_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Round half up at the Q8.8 binary point, then clamp to the sample range.
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(
        input logic signed [WIDE_WIDTH-1:0] acc
    );
        logic signed [WIDE_WIDTH-1:0] r;
        r = (acc + RND_HALF) >>> FRAC_BITS;
        if (r > SAT_MAX_W) begin
            return SAT_MAX;
        end else if (r < SAT_MIN_W) begin
            return SAT_MIN;
        end else begin
            return r[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/conv1d_dw_k3_if.sv
// rtl/conv1d_dw_k3_if.sv - sample-in / sample-out handshake bundle for the depthwise convolver
interface conv1d_dw_k3_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic                  last_out;

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, last_out
    );

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, last_out
    );
endinterface

// File: rtl/conv1d_dw_k3_mac3_sat.sv
// rtl/conv1d_dw_k3_mac3_sat.sv - combinational 3-tap MAC with bias, rounding and saturation
module mac3_sat
    import fxp_q88_pkg::*;
#(
    parameter int ACC_WIDTH = 36
) (
    input  logic signed [DATA_WIDTH-1:0] w0,
    input  logic signed [DATA_WIDTH-1:0] w1,
    input  logic signed [DATA_WIDTH-1:0] w2,
    input  logic signed [DATA_WIDTH-1:0] x0,
    input  logic signed [DATA_WIDTH-1:0] x1,
    input  logic signed [DATA_WIDTH-1:0] x2,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    logic signed [2*DATA_WIDTH-1:0] p0;
    logic signed [2*DATA_WIDTH-1:0] p1;
    logic signed [2*DATA_WIDTH-1:0] p2;
    logic signed [ACC_WIDTH-1:0]    acc;

    // Full-precision products and sum; bias is aligned to the product's Q16.16 point.
    always_comb begin
        p0  = w0 * x0;
        p1  = w1 * x1;
        p2  = w2 * x2;
        acc = ACC_WIDTH'(p0) + ACC_WIDTH'(p1) + ACC_WIDTH'(p2)
            + (ACC_WIDTH'(b) <<< FRAC_BITS);
        y   = round_sat(64'(acc));
    end

endmodule

// File: rtl/conv1d_dw_k3.sv
// rtl/conv1d_dw_k3.sv - streaming depthwise k=3 same-padded 1-D convolution, channel-major
module conv1d_dw_k3
    import fxp_q88_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int FRAME_LEN = 16,
    parameter int ACC_WIDTH = 36
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CHANNELS*3*DATA_WIDTH-1:0] weights,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   bias,
    conv1d_dw_k3_if.slave                    s,
    output logic                             busy,
    output logic                             done
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int POS_W = $clog2(FRAME_LEN);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);

    state_t state_q;
    state_t state_d;

    logic [CH_W-1:0]               ch_q;
    logic [POS_W-1:0]              pos_q;
    logic signed [DATA_WIDTH-1:0]  xm1_q;
    logic signed [DATA_WIDTH-1:0]  x0_q;
    logic signed [DATA_WIDTH-1:0]  w_q [CHANNELS][3];
    logic signed [DATA_WIDTH-1:0]  b_q [CHANNELS];

    logic [DATA_WIDTH-1:0]         dout_q;
    logic                          vout_q;
    logic                          lout_q;

    logic                          out_free;
    logic                          ready_c;
    logic                          accept;
    logic                          load;
    logic                          load_last;
    logic signed [DATA_WIDTH-1:0]  x_next;
    logic signed [DATA_WIDTH-1:0]  w_sel0;
    logic signed [DATA_WIDTH-1:0]  w_sel1;
    logic signed [DATA_WIDTH-1:0]  w_sel2;
    logic signed [DATA_WIDTH-1:0]  b_sel;
    logic signed [DATA_WIDTH-1:0]  y;

    assign out_free = !vout_q || s.ready_out;
    assign accept   = s.valid_in && ready_c;
    // The right-hand tap is the zero pad once the channel's last sample has been taken.
    assign x_next   = (state_q == ST_FLUSH) ? '0 : s.data_in;

    assign s.ready_in  = ready_c;
    assign s.data_out  = dout_q;
    assign s.valid_out = vout_q;
    assign s.last_out  = lout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one FILL/RUN/FLUSH pass per channel, DONE after the last one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL;
            ST_FILL:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (accept && pos_q == POS_LAST) state_d = ST_FLUSH;
            ST_FLUSH: if (out_free) state_d = (ch_q == CH_LAST) ? ST_DONE : ST_FILL;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and output-register load strobes.
    always_comb begin
        ready_c   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        case (state_q)
            ST_FILL: begin
                busy    = 1'b1;
                ready_c = out_free;
            end
            ST_RUN: begin
                busy    = 1'b1;
                ready_c = out_free;
                load    = s.valid_in && out_free;
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                load      = out_free;
                load_last = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Coefficients of the channel currently streaming.
    always_comb begin
        w_sel0 = w_q[ch_q][0];
        w_sel1 = w_q[ch_q][1];
        w_sel2 = w_q[ch_q][2];
        b_sel  = b_q[ch_q];
    end

    mac3_sat #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .w0 (w_sel0),
        .w1 (w_sel1),
        .w2 (w_sel2),
        .x0 (xm1_q),
        .x1 (x0_q),
        .x2 (x_next),
        .b  (b_sel),
        .y  (y)
    );

    // Coefficient latch, channel/position counters and the two-sample history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            pos_q <= '0;
            xm1_q <= '0;
            x0_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                b_q[c] <= '0;
                for (int k = 0; k < 3; k++) begin
                    w_q[c][k] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ch_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            b_q[c] <= bias[c*DATA_WIDTH +: DATA_WIDTH];
                            for (int k = 0; k < 3; k++) begin
                                w_q[c][k] <= weights[(3*c+k)*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        xm1_q <= '0;
                        x0_q  <= s.data_in;
                        pos_q <= POS_W'(1);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        xm1_q <= x0_q;
                        x0_q  <= s.data_in;
                        if (pos_q != POS_LAST) begin
                            pos_q <= pos_q + POS_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_free) begin
                        xm1_q <= '0;
                        x0_q  <= '0;
                        if (ch_q != CH_LAST) begin
                            ch_q <= ch_q + CH_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: a new load wins over a same-cycle handshake; otherwise hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vout_q <= 1'b0;
            lout_q <= 1'b0;
        end else if (load) begin
            dout_q <= y;
            vout_q <= 1'b1;
            lout_q <= load_last;
        end else if (vout_q && s.ready_out) begin
            vout_q <= 1'b0;
            lout_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv1d_dw_k3.sv
// tb/tb_conv1d_dw_k3.sv - directed self-checking bench for conv1d_dw_k3
module tb_conv1d_dw_k3;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int L  = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CH*3*DW-1:0] weights = '0;
    logic [CH*DW-1:0]   bias    = '0;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit bp_en  = 1'b0;
    bit gap_en = 1'b0;

    logic [DW:0]    exp_q[$];
    logic [DW:0]    exp_item;
    logic           hold_v = 1'b0;
    logic [DW-1:0]  hold_d = '0;
    logic           hold_l = 1'b0;

    conv1d_dw_k3_if #(.DATA_WIDTH(DW)) s_if ();

    conv1d_dw_k3 #(
        .CHANNELS  (CH),
        .FRAME_LEN (L),
        .ACC_WIDTH (36)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .weights (weights),
        .bias    (bias),
        .s       (s_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [DW-1:0] d, input logic l);
        exp_q.push_back({d, l});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] x);
        int n;
        n = 0;
        if (gap_en) repeat ($urandom_range(0, 2)) step();
        s_if.data_in  = x;
        s_if.valid_in = 1'b1;
        @(negedge clk);
        while (!s_if.ready_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(n < 100), 32'd1);
        step();
        s_if.valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 300), 32'd1);
        repeat (2) step();
    endtask

    task automatic load_coef_a();
        weights = {16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0100};
        bias    = {16'h0080, 16'h0000};
    endtask

    task automatic frame_a(input string tag);
        load_coef_a();
        expect_out(16'h0300, 1'b0); expect_out(16'h0600, 1'b0);
        expect_out(16'h0900, 1'b0); expect_out(16'h0700, 1'b1);
        expect_out(16'h0081, 1'b0); expect_out(16'h0082, 1'b0);
        expect_out(16'h0083, 1'b0); expect_out(16'h0084, 1'b1);
        done_cnt = 0;
        pulse_start();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        send(16'h0100); send(16'h0200); send(16'h0300); send(16'h0400);
        send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
        wait_idle({tag, "_drain"});
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    // Downstream ready: always 1, or a coin toss every cycle under backpressure.
    initial begin
        s_if.ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.ready_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output scoreboard, stall-stability check and done pulse counter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v) begin
                chk("stall_valid", 32'(s_if.valid_out), 32'd1);
                chk("stall_data", 32'(s_if.data_out), 32'(hold_d));
                chk("stall_last", 32'(s_if.last_out), 32'(hold_l));
            end
            hold_v = s_if.valid_out && !s_if.ready_out;
            hold_d = s_if.data_out;
            hold_l = s_if.last_out;
            if (s_if.valid_out && s_if.ready_out) begin
                chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    chk("out_data", 32'(s_if.data_out), 32'(exp_item[DW:1]));
                    chk("out_last", 32'(s_if.last_out), 32'(exp_item[0]));
                end
            end
            if (done) done_cnt++;
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.data_in  = '0;
        s_if.valid_in = 1'b0;
        repeat (3) step();

        chk("rst_valid_out", 32'(s_if.valid_out), 32'd0);
        chk("rst_data_out", 32'(s_if.data_out), 32'd0);
        chk("rst_last_out", 32'(s_if.last_out), 32'd0);
        chk("rst_ready_in", 32'(s_if.ready_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        rst_n = 1'b1;
        step();

        s_if.valid_in = 1'b1;
        s_if.data_in  = 16'h1234;
        @(negedge clk);
        chk("idle_ready_in", 32'(s_if.ready_in), 32'd0);
        step();
        s_if.valid_in = 1'b0;
        step();

        frame_a("sum_identity");

        weights = {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
        bias    = '0;
        for (int i = 0; i < L; i++) expect_out(16'h7FFF, 1'(i == L - 1));
        for (int i = 0; i < L; i++) expect_out(16'h8000, 1'(i == L - 1));
        done_cnt = 0;
        pulse_start();
        for (int i = 0; i < L; i++) send(16'h7F00);
        for (int i = 0; i < L; i++) send(16'h8000);
        wait_idle("sat_drain");
        chk("sat_done_cnt", 32'(done_cnt), 32'd1);

        weights = {16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0080, 16'h0000};
        bias    = '0;
        for (int i = 0; i < L; i++) expect_out(16'h0001, 1'(i == L - 1));
        for (int i = 0; i < L; i++) expect_out(16'h0000, 1'(i == L - 1));
        pulse_start();
        for (int i = 0; i < L; i++) send(16'h0001);
        for (int i = 0; i < L; i++) send(16'hFFFF);
        wait_idle("round_drain");

        bp_en  = 1'b1;
        gap_en = 1'b1;
        frame_a("backpressure");
        bp_en  = 1'b0;
        gap_en = 1'b0;
        repeat (2) step();

        load_coef_a();
        expect_out(16'h0300, 1'b0); expect_out(16'h0600, 1'b0);
        expect_out(16'h0900, 1'b0); expect_out(16'h0700, 1'b1);
        expect_out(16'h0081, 1'b0);
        pulse_start();
        send(16'h0100);
        send(16'h0200);
        weights = '1;
        bias    = '1;
        pulse_start();
        chk("poke_busy", 32'(busy), 32'd1);
        send(16'h0300);
        send(16'h0400);
        send(16'h0001);
        send(16'h0002);
        repeat (2) step();
        chk("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        chk("pre_reset_busy", 32'(busy), 32'd1);

        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", 32'(s_if.valid_out), 32'd0);
        chk("midrst_data_out", 32'(s_if.data_out), 32'd0);
        chk("midrst_last_out", 32'(s_if.last_out), 32'd0);
        chk("midrst_ready_in", 32'(s_if.ready_in), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();

        frame_a("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
